// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its multi-byte sequencer:
// opcode table and sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OpLoad  = 4'b0000;
  localparam logic [3:0] OpAnd   = 4'b0001;
  localparam logic [3:0] OpOr    = 4'b0010;
  localparam logic [3:0] OpXor   = 4'b0011;
  localparam logic [3:0] OpNot   = 4'b0100;
  localparam logic [3:0] OpShl   = 4'b0101;
  localparam logic [3:0] OpShr   = 4'b0110;
  localparam logic [3:0] OpAddc  = 4'b0111;
  localparam logic [3:0] OpAdd   = 4'b1000;
  localparam logic [3:0] OpSubc  = 4'b1001;
  localparam logic [3:0] OpSub   = 4'b1010;
  localparam logic [3:0] OpInc   = 4'b1011;
  localparam logic [3:0] OpDec   = 4'b1100;
  localparam logic [3:0] OpCmp   = 4'b1101;
  localparam logic [3:0] OpPassB = 4'b1110;
  localparam logic [3:0] OpNop   = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_t;

  // Opcode for one byte step of a multi-byte add/subtract.
  function automatic logic [3:0] chain_op(input logic sub);
    return sub ? OpSubc : OpAddc;
  endfunction

endpackage

// File: rtl/carry_borrow_gen.sv
// Byte-level carry (add) or borrow (subtract) generator for the multi-byte chain.
module carry_borrow_gen (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic       cout
);

  logic [8:0] sum;
  logic [8:0] subtrahend;

  // 9-bit arithmetic so b + cin never truncates.
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    subtrahend = {1'b0, b} + {8'd0, cin};
    cout       = sub ? ({1'b0, a} < subtrahend) : sum[8];
  end

endmodule

// File: rtl/alu_multibyte_seq.sv
// Drives the shared 8-bit ALU one byte per cycle to perform a multi-byte
// ADD or SUB with a locally computed carry/borrow chain.
module alu_multibyte_seq
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  OpSel,
  input  logic [8*NBYTES-1:0]   OperandA,
  input  logic [8*NBYTES-1:0]   OperandB,
  output logic                  Busy,
  output logic                  Done,
  output logic [8*NBYTES-1:0]   Result,
  output logic                  CarryOut,
  output logic                  ResultZero,
  output logic [7:0]            AluInput,
  output logic [7:0]            AluAcc,
  output logic [3:0]            AluOp,
  output logic                  AluCin,
  input  logic [7:0]            AluOut,
  input  logic                  AluZero
);

  localparam int unsigned IdxW = $clog2(NBYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  seq_state_t              state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic                    zacc_q, zacc_d;
  logic                    sub_q, sub_d;
  logic [NBYTES-1:0][7:0]  a_q, a_d;
  logic [NBYTES-1:0][7:0]  b_q, b_d;
  logic [NBYTES-1:0][7:0]  result_q, result_d;
  logic                    next_carry;

  carry_borrow_gen u_carry (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sub  (sub_q),
    .cout (next_carry)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    zacc_d     = zacc_q;
    sub_d      = sub_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    AluInput   = 8'd0;
    AluAcc     = 8'd0;
    AluOp      = OpLoad;
    AluCin     = 1'b0;
    Busy       = (state_q != StIdle);
    Done       = (state_q == StDone);
    CarryOut   = 1'b0;
    ResultZero = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          a_d     = OperandA;
          b_d     = OperandB;
          sub_d   = OpSel;
          idx_d   = '0;
          carry_d = 1'b0;
          zacc_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        AluInput        = a_q[idx_q];
        AluAcc          = b_q[idx_q];
        AluCin          = carry_q;
        AluOp           = chain_op(sub_q);
        result_d[idx_q] = AluOut;
        carry_d         = next_carry;
        zacc_d          = zacc_q & AluZero;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        CarryOut   = carry_q;
        ResultZero = zacc_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Result = result_q;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Directed and random checks of the multi-byte sequencer driving a
// behavioural 8-bit ALU.
module tb_alu_multibyte_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_sel;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        result_zero;
  logic [7:0]  alu_input;
  logic [7:0]  alu_acc;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic [7:0]  alu_out;
  logic        alu_zero;

  int total = 0;
  int bad   = 0;

  alu_multibyte_seq #(.NBYTES(4)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .OpSel      (op_sel),
    .OperandA   (opa),
    .OperandB   (opb),
    .Busy       (busy),
    .Done       (done),
    .Result     (result),
    .CarryOut   (carry_out),
    .ResultZero (result_zero),
    .AluInput   (alu_input),
    .AluAcc     (alu_acc),
    .AluOp      (alu_op),
    .AluCin     (alu_cin),
    .AluOut     (alu_out),
    .AluZero    (alu_zero)
  );

  // Behavioural ALU: ADDC = Input + Acc + Cin, SUBC = Input - Acc - Cin.
  always_comb begin
    alu_out = 8'd0;
    case (alu_op)
      4'b0000: alu_out = alu_input;
      4'b0111: alu_out = alu_input + alu_acc + {7'd0, alu_cin};
      4'b1001: alu_out = alu_input - alu_acc - {7'd0, alu_cin};
      default: alu_out = 8'd0;
    endcase
    alu_zero = (alu_out == 8'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_result"}, {32'd0, result}, 64'd0);
    check({tag, "_cout"}, {63'd0, carry_out}, 64'd0);
    check({tag, "_zero"}, {63'd0, result_zero}, 64'd0);
    check({tag, "_alu"}, {43'd0, alu_input, alu_acc, alu_op, alu_cin}, 64'd0);
  endtask

  // Issue one op; lat counts edges from the accepting edge (=1) to Done visible.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] res, output logic co, output logic z,
                        output int lat);
    start  = 1'b1;
    opa    = a;
    opb    = b;
    op_sel = sub;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    res = result;
    co  = carry_out;
    z   = result_zero;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] res;
    logic        co;
    logic        z;
    int          lat;
    int          dc;
    logic [32:0] model;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    reset  = 1'b1;
    start  = 1'b0;
    op_sel = 1'b0;
    opa    = '0;
    opb    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // 1: ADD 0xFF + 1, with latency and live ALU drive check
    start  = 1'b1;
    opa    = 32'h0000_00FF;
    opb    = 32'h0000_0001;
    op_sel = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("run_alu_input", {56'd0, alu_input}, 64'hFF);
    check("run_alu_acc", {56'd0, alu_acc}, 64'h01);
    check("run_alu_op", {60'd0, alu_op}, 64'h7);
    check("run_busy", {63'd0, busy}, 64'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t1_latency", lat, 5);
    check("t1_result", {32'd0, result}, 64'h0000_0100);
    check("t1_cout", {63'd0, carry_out}, 64'd0);
    check("t1_zero", {63'd0, result_zero}, 64'd0);
    @(posedge clk);
    #1;
    check("t1_idle_after", {62'd0, busy, done}, 64'd0);

    // 2: ADD wraps to zero
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, res, co, z, lat);
    check("t2_result", {32'd0, res}, 64'h0);
    check("t2_cout", {63'd0, co}, 64'd1);
    check("t2_zero", {63'd0, z}, 64'd1);

    // 3: SUB with borrow through bytes
    run_op(32'h0000_0100, 32'h0000_0001, 1'b1, res, co, z, lat);
    check("t3a_result", {32'd0, res}, 64'h0000_00FF);
    check("t3a_borrow", {63'd0, co}, 64'd0);
    check("t3a_zero", {63'd0, z}, 64'd0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1, res, co, z, lat);
    check("t3b_result", {32'd0, res}, 64'hFFFF_FFFF);
    check("t3b_borrow", {63'd0, co}, 64'd1);

    // 4: Start held high with changing operands while busy
    start  = 1'b1;
    opa    = 32'h0000_00FF;
    opb    = 32'h0000_0001;
    op_sel = 1'b0;
    @(posedge clk);
    #1;
    dc = 0;
    for (int i = 0; i < 4; i++) begin
      opa    = 32'hA5A5_0000 + i;
      opb    = 32'h5A5A_1234;
      op_sel = 1'b1;
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    check("t4_done_count", dc, 1);
    check("t4_done_now", {63'd0, done}, 64'd1);
    check("t4_result", {32'd0, result}, 64'h0000_0100);
    opa    = 32'h1234_5678;
    opb    = 32'h1111_1111;
    op_sel = 1'b0;
    @(posedge clk);
    #1;
    check("t4_idle_gap", {62'd0, busy, done}, 64'd0);
    @(posedge clk);
    #1;
    check("t4_b2b_accept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t4_b2b_latency", lat, 5);
    check("t4_b2b_result", {32'd0, result}, 64'h2345_6789);
    @(posedge clk);
    #1;

    // 5: reset while RUN at idx=2
    start  = 1'b1;
    opa    = 32'h0101_0101;
    opb    = 32'h0202_0202;
    op_sel = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("t5_mid_input", {56'd0, alu_input}, 64'h01);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("t5_abort");
    reset = 1'b0;
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, res, co, z, lat);
    check("t5_after_latency", lat, 5);
    check("t5_after_result", {32'd0, res}, 64'h0001_0000);
    check("t5_after_cout", {63'd0, co}, 64'd0);

    // 6: random against a 33-bit reference
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (n % 10 == 0) rb = ra;
      model = rs ? ({1'b0, ra} - {1'b0, rb}) : ({1'b0, ra} + {1'b0, rb});
      run_op(ra, rb, rs, res, co, z, lat);
      check("rand_result", {32'd0, res}, {32'd0, model[31:0]});
      check("rand_cout", {63'd0, co}, {63'd0, model[32]});
      check("rand_zero", {63'd0, z}, {63'd0, (model[31:0] == 32'd0)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
